// File: rtl/sprite_pixel_scheduler_pkg.sv
// Shared constants and the sprite register layout for the sprite pixel scheduler.
package sprite_pixel_scheduler_pkg;

  localparam int NUM_SPRITES = 4;
  localparam int SPR_W       = 32;
  localparam int SPR_H       = 32;
  localparam int IMG_BITS    = 3;
  localparam int DATA_WIDTH  = 24;
  localparam int SPR_W_LOG2  = $clog2(SPR_W);
  localparam int SPR_H_LOG2  = $clog2(SPR_H);
  localparam int ROM_AW      = IMG_BITS + SPR_H_LOG2 + SPR_W_LOG2;

  localparam logic [1:0] FLD_X    = 2'd0;
  localparam logic [1:0] FLD_Y    = 2'd1;
  localparam logic [1:0] FLD_CTRL = 2'd2;

  typedef struct packed {
    logic [9:0]          x;
    logic [9:0]          y;
    logic                en;
    logic [IMG_BITS-1:0] img;
  } sprite_reg_t;

endpackage

// File: rtl/sprite_pixel_scheduler_hit_unit.sv
// Bounding-box hit test of one sprite against the current pixel, plus the
// row/column offset of that pixel inside the sprite image.
module sprite_hit_unit
  import sprite_pixel_scheduler_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32
) (
  input  logic                     [9:0] hcount_i,
  input  logic                     [9:0] vcount_i,
  input  sprite_reg_t                    spr_i,
  output logic                           hit_o,
  output logic [$clog2(SPR_H)-1:0]       row_o,
  output logic [$clog2(SPR_W)-1:0]       col_o
);

  localparam int WL = $clog2(SPR_W);
  localparam int HL = $clog2(SPR_H);

  logic inX;
  logic inY;

  // 11-bit compares keep a sprite near x/y=1023 from wrapping back to 0
  assign inX = ({1'b0, hcount_i} >= {1'b0, spr_i.x}) &&
               ({1'b0, hcount_i} <  ({1'b0, spr_i.x} + 11'(SPR_W)));
  assign inY = ({1'b0, vcount_i} >= {1'b0, spr_i.y}) &&
               ({1'b0, vcount_i} <  ({1'b0, spr_i.y} + 11'(SPR_H)));

  assign hit_o = spr_i.en && inX && inY;
  assign col_o = hcount_i[WL-1:0] - spr_i.x[WL-1:0];
  assign row_o = vcount_i[HL-1:0] - spr_i.y[HL-1:0];

endmodule

// File: rtl/sprite_pixel_scheduler.sv
// Per-pixel sprite ownership, ROM fetch and collision flagging, with sprite
// registers double-buffered so CPU writes only take effect at frame start.
module sprite_pixel_scheduler
  import sprite_pixel_scheduler_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int IMG_BITS    = 3,
  parameter int DATA_WIDTH  = 24,
  parameter int ROM_AW      = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_tick,
  input  logic                  frame_start,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic                  bright,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [9:0]            wr_data,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] pixel,
  output logic                  pix_en,
  output logic [9:0]            hcount_o,
  output logic [9:0]            vcount_o,
  output logic                  bright_o,
  output logic                  collision
);

  localparam int WL = $clog2(SPR_W);
  localparam int HL = $clog2(SPR_H);

  sprite_reg_t shadow_q [NUM_SPRITES];
  sprite_reg_t active_q [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] hit;
  logic [HL-1:0]          row [NUM_SPRITES];
  logic [WL-1:0]          col [NUM_SPRITES];

  logic              anyHit;
  logic [ROM_AW-1:0] winAddr;
  logic              collNow;

  logic              hit1_q, bright1_q;
  logic [9:0]        h1_q, v1_q;
  logic [ROM_AW-1:0] rom_addr_q;

  logic                  pix_en_q, bright2_q;
  logic [DATA_WIDTH-1:0] pixel_q;
  logic [9:0]            h2_q, v2_q;

  logic acc_q, acc_d;
  logic collision_q;

  // Nonblocking semantics give the commit the pre-write shadow on a same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (frame_start) active_q[i] <= shadow_q[i];
        if (wr_en && (wr_addr[3:2] == 2'(i))) begin
          case (wr_addr[1:0])
            FLD_X:    shadow_q[i].x <= wr_data;
            FLD_Y:    shadow_q[i].y <= wr_data;
            FLD_CTRL: begin
              shadow_q[i].en  <= wr_data[IMG_BITS];
              shadow_q[i].img <= wr_data[IMG_BITS-1:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit_unit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .hcount_i (hcount),
      .vcount_i (vcount),
      .spr_i    (active_q[g]),
      .hit_o    (hit[g]),
      .row_o    (row[g]),
      .col_o    (col[g])
    );
  end

  // Walk from the highest index down so the lowest hitting sprite is kept
  always_comb begin
    anyHit  = 1'b0;
    winAddr = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        anyHit  = 1'b1;
        winAddr = {active_q[i].img, row[i], col[i]};
      end
    end
  end

  assign collNow = pix_tick && bright && hit[0] && (|hit[NUM_SPRITES-1:1]);
  assign acc_d   = (frame_start ? 1'b0 : acc_q) | collNow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit1_q      <= 1'b0;
      bright1_q   <= 1'b0;
      h1_q        <= '0;
      v1_q        <= '0;
      rom_addr_q  <= '0;
      pix_en_q    <= 1'b0;
      bright2_q   <= 1'b0;
      pixel_q     <= '0;
      h2_q        <= '0;
      v2_q        <= '0;
      acc_q       <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (frame_start) collision_q <= acc_q;
      if (pix_tick) begin
        hit1_q    <= anyHit;
        bright1_q <= bright;
        h1_q      <= hcount;
        v1_q      <= vcount;
        if (anyHit) rom_addr_q <= winAddr;
        pix_en_q  <= hit1_q && bright1_q;
        pixel_q   <= (hit1_q && bright1_q) ? rom_data : '0;
        bright2_q <= bright1_q;
        h2_q      <= h1_q;
        v2_q      <= v1_q;
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pixel     = pixel_q;
  assign pix_en    = pix_en_q;
  assign hcount_o  = h2_q;
  assign vcount_o  = v2_q;
  assign bright_o  = bright2_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_sprite_pixel_scheduler.sv
// Directed bench for sprite_pixel_scheduler: a behavioural sprite model fills a
// scoreboard of expected pipeline outputs that is drained as pixels emerge.
module tb_sprite_pixel_scheduler;
  import sprite_pixel_scheduler_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  pix_tick;
  logic                  frame_start;
  logic [9:0]            hcount;
  logic [9:0]            vcount;
  logic                  bright;
  logic                  wr_en;
  logic [3:0]            wr_addr;
  logic [9:0]            wr_data;
  logic [ROM_AW-1:0]     rom_addr;
  logic [DATA_WIDTH-1:0] rom_data = '0;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  pix_en;
  logic [9:0]            hcount_o;
  logic [9:0]            vcount_o;
  logic                  bright_o;
  logic                  collision;

  typedef struct {
    logic                  pixEn;
    logic [DATA_WIDTH-1:0] pixel;
    logic [9:0]            h;
    logic [9:0]            v;
    logic                  b;
  } exp_t;

  exp_t sbq[$];

  int shX[4], shY[4], shEn[4], shImg[4];
  int acX[4], acY[4], acEn[4], acImg[4];
  int expRomAddr;
  bit accModel;
  bit expColl;
  int assertCount = 0;
  int failCount   = 0;

  sprite_pixel_scheduler #(
    .NUM_SPRITES(NUM_SPRITES), .SPR_W(SPR_W), .SPR_H(SPR_H),
    .IMG_BITS(IMG_BITS), .DATA_WIDTH(DATA_WIDTH), .ROM_AW(ROM_AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_tick    (pix_tick),
    .frame_start (frame_start),
    .hcount      (hcount),
    .vcount      (vcount),
    .bright      (bright),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel       (pixel),
    .pix_en      (pix_en),
    .hcount_o    (hcount_o),
    .vcount_o    (vcount_o),
    .bright_o    (bright_o),
    .collision   (collision)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_WIDTH-1:0] romFn(input logic [ROM_AW-1:0] a);
    return {11'h3C1, a};
  endfunction

  // Synchronous ROM with one clock of read latency
  always @(posedge clk) rom_data <= romFn(rom_addr);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 4; i++) begin
      shX[i] = 0; shY[i] = 0; shEn[i] = 0; shImg[i] = 0;
      acX[i] = 0; acY[i] = 0; acEn[i] = 0; acImg[i] = 0;
    end
    expRomAddr = 0;
    accModel   = 1'b0;
    expColl    = 1'b0;
    sbq.delete();
    sbq.push_back('{1'b0, '0, '0, '0, 1'b0});
  endtask

  task automatic modelWrite(input int spr, input int fld, input int data);
    case (fld)
      0: shX[spr] = data;
      1: shY[spr] = data;
      2: begin shEn[spr] = (data >> 3) & 1; shImg[spr] = data & 7; end
      default: ;
    endcase
  endtask

  task automatic writeReg(input int spr, input int fld, input int data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 4'(spr * 4 + fld);
    wr_data = 10'(data);
    @(negedge clk);
    wr_en = 1'b0;
    modelWrite(spr, fld, data);
  endtask

  task automatic frameStart(input bit doWrite = 1'b0, input int spr = 0,
                            input int fld = 0, input int data = 0);
    @(negedge clk);
    frame_start = 1'b1;
    if (doWrite) begin
      wr_en   = 1'b1;
      wr_addr = 4'(spr * 4 + fld);
      wr_data = 10'(data);
    end
    @(negedge clk);
    frame_start = 1'b0;
    wr_en       = 1'b0;
    expColl  = accModel;
    accModel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acX[i] = shX[i]; acY[i] = shY[i]; acEn[i] = shEn[i]; acImg[i] = shImg[i];
    end
    if (doWrite) modelWrite(spr, fld, data);
    checkOutput("collision", {31'd0, collision}, {31'd0, expColl});
  endtask

  task automatic applyStimulus(input int h, input int v, input bit b);
    int   winner;
    bit   hitFlag[4];
    exp_t e;
    exp_t got;
    winner = -1;
    for (int i = 0; i < 4; i++) begin
      hitFlag[i] = (acEn[i] != 0) && (h >= acX[i]) && (h < acX[i] + SPR_W) &&
                   (v >= acY[i]) && (v < acY[i] + SPR_H);
      if (hitFlag[i] && winner < 0) winner = i;
    end
    if (winner >= 0)
      expRomAddr = acImg[winner] * 1024 + (v - acY[winner]) * 32 + (h - acX[winner]);
    if (b && hitFlag[0] && (hitFlag[1] || hitFlag[2] || hitFlag[3])) accModel = 1'b1;
    e.pixEn = (winner >= 0) && b;
    e.pixel = e.pixEn ? romFn(ROM_AW'(expRomAddr)) : '0;
    e.h     = 10'(h);
    e.v     = 10'(v);
    e.b     = b;
    sbq.push_back(e);

    @(negedge clk);
    hcount   = 10'(h);
    vcount   = 10'(v);
    bright   = b;
    pix_tick = 1'b1;
    @(negedge clk);
    pix_tick = 1'b0;
    @(negedge clk);

    checkOutput("rom_addr", 32'(rom_addr), 32'(expRomAddr));
    got = sbq.pop_front();
    checkOutput("pix_en",   {31'd0, pix_en},   {31'd0, got.pixEn});
    checkOutput("pixel",    32'(pixel),        32'(got.pixel));
    checkOutput("hcount_o", 32'(hcount_o),     32'(got.h));
    checkOutput("vcount_o", 32'(vcount_o),     32'(got.v));
    checkOutput("bright_o", {31'd0, bright_o}, {31'd0, got.b});
  endtask

  task automatic checkAllZero(input string phase);
    checkOutput({phase, "_pix_en"},    {31'd0, pix_en},    32'd0);
    checkOutput({phase, "_pixel"},     32'(pixel),         32'd0);
    checkOutput({phase, "_rom_addr"},  32'(rom_addr),      32'd0);
    checkOutput({phase, "_hcount_o"},  32'(hcount_o),      32'd0);
    checkOutput({phase, "_vcount_o"},  32'(vcount_o),      32'd0);
    checkOutput({phase, "_bright_o"},  {31'd0, bright_o},  32'd0);
    checkOutput({phase, "_collision"}, {31'd0, collision}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; pix_tick = 1'b0; frame_start = 1'b0;
    hcount = '0; vcount = '0; bright = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    resetModel();
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Single sprite at (100,50) image 2
    writeReg(0, 0, 100);
    writeReg(0, 1, 50);
    writeReg(0, 2, 'hA);
    frameStart();
    applyStimulus(100, 50, 1'b1);
    applyStimulus(101, 50, 1'b1);

    // Overlapping sprites: sprite 0 has priority, then sprite 1 once 0 is disabled
    writeReg(1, 0, 110);
    writeReg(1, 1, 40);
    writeReg(1, 2, 'hD);
    frameStart();
    applyStimulus(120, 60, 1'b1);
    writeReg(0, 2, 'h2);
    frameStart();
    applyStimulus(120, 60, 1'b1);

    // Shadow writes only take effect at frame start
    writeReg(0, 2, 'hA);
    frameStart();
    writeReg(0, 0, 200);
    applyStimulus(100, 50, 1'b1);
    frameStart(1'b1, 0, 0, 300);
    applyStimulus(200, 50, 1'b1);
    applyStimulus(300, 50, 1'b1);
    frameStart();
    applyStimulus(300, 50, 1'b1);

    // Sprite at the right edge must not wrap to column 0
    writeReg(2, 0, 1000);
    writeReg(2, 1, 0);
    writeReg(2, 2, 'hF);
    frameStart();
    applyStimulus(0, 0, 1'b1);
    applyStimulus(7, 0, 1'b1);
    applyStimulus(1000, 0, 1'b1);
    applyStimulus(1023, 0, 1'b1);
    applyStimulus(1023, 31, 1'b1);
    applyStimulus(1023, 32, 1'b1);

    // Collision between sprite 0 and sprite 3, then a clean frame
    writeReg(3, 0, 320);
    writeReg(3, 1, 60);
    writeReg(3, 2, 'h9);
    frameStart();
    applyStimulus(325, 65, 1'b1);
    frameStart();
    applyStimulus(300, 50, 1'b1);
    frameStart();

    // Blanked pixel under a sprite, then reset in the middle of a scan
    applyStimulus(305, 55, 1'b0);
    applyStimulus(306, 55, 1'b1);
    applyStimulus(306, 56, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkAllZero("midreset");
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    applyStimulus(300, 50, 1'b1);
    applyStimulus(300, 50, 1'b1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_scheduler.md
Name: sprite_pixel_scheduler

Overview:
- Decides, per displayed pixel, which sprite owns that pixel, then fetches the sprite's colour from the shared sprite ROM.
- Drives the downstream pixel compositor's pix_en/pixel inputs. Forwards hcount/vcount/bright delayed so they stay aligned with the pixel.
- Holds CPU-written sprite registers in shadow copies and commits them only at frame start, so no tearing.
- Flags sticky bounding-box collisions between sprite 0 (the player) and any other sprite.

Parameters:
- NUM_SPRITES, 4, number of sprite slots; fixed priority, lowest index wins.
- SPR_W, 32, sprite width in pixels; power of 2.
- SPR_H, 32, sprite height in pixels; power of 2.
- IMG_BITS, 3, image-select width; ROM holds 2^IMG_BITS images of SPR_W x SPR_H.
- DATA_WIDTH, 24, ROM word / pixel width.
- ROM_AW, 13, ROM address width = IMG_BITS + log2(SPR_H) + log2(SPR_W).

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  asynchronous, active-high reset
- pix_tick  in  1  pipeline advance enable; one pixel per tick
- frame_start  in  1  one-clk pulse at start of vertical blank
- hcount  in  10  current pixel x
- vcount  in  10  current pixel y
- bright  in  1  visible-area flag
- wr_en  in  1  CPU register write strobe; single cycle, always accepted
- wr_addr  in  4  {sprite[1:0], field[1:0]}
- wr_data  in  10  write data
- rom_addr  out  ROM_AW  sprite ROM address; synchronous ROM, 1-clk read latency
- rom_data  in  DATA_WIDTH  ROM read data
- pixel  out  DATA_WIDTH  sprite colour to compositor
- pix_en  out  1  sprite owns this pixel
- hcount_o  out  10  hcount delayed by pipeline
- vcount_o  out  10  vcount delayed by pipeline
- bright_o  out  1  bright delayed by pipeline
- collision  out  1  sprite 0 overlapped another sprite during the previous frame

Behaviour:
- Reset (async): all shadow and active registers are 0, so every sprite is disabled. All outputs are 0. The collision accumulator is 0.
- Register fields:
  - field 0 = x[9:0]
  - field 1 = y[9:0]
  - field 2 = {en = wr_data[IMG_BITS], img = wr_data[IMG_BITS-1:0]}
  - field 3 = ignored
  - Unused wr_data bits are ignored.
  - Writes go to shadow only and land on the clk after wr_en.
- Commit: on frame_start, active <= shadow for all sprites simultaneously.
  - A write in the same cycle as frame_start updates shadow, but active takes the pre-write shadow value; the new value commits next frame.
- Hit test (stage 1, on pix_tick): sprite i hits when en_i AND x_i <= hcount < x_i+SPR_W AND y_i <= vcount < y_i+SPR_H.
  - Sums are computed at 11 bits, so a sprite at x=1000 does not wrap to column 0.
  - The winner is the lowest hitting index.
- Address: rom_addr is registered as {img_w, (vcount-y_w)[log2 SPR_H-1:0], (hcount-x_w)[log2 SPR_W-1:0]}.
  - With no hit, rom_addr holds its previous value.
- Stage 2 (next pix_tick):
  - pix_en = hit_d AND bright_d.
  - pixel = rom_data when pix_en, else 0.
  - A transparent colour (0) is passed through unchanged; the compositor handles transparency.
- Latency: exactly 2 pix_ticks from hcount/vcount/bright to pixel/pix_en/hcount_o/vcount_o/bright_o.
  - All outputs hold between ticks.
  - pix_tick must be spaced ≥2 clk apart so the ROM data is valid at stage 2.
- Collision:
  - Any tick with bright=1 where sprite 0 hits and any other sprite hits sets the accumulator.
  - On frame_start: collision <= acc, then acc is cleared.
  - A hit coincident with frame_start accumulates into the new frame.
  - collision holds for one full frame.
- Mid-operation: rst asserted at any time clears the pipeline immediately. Outputs are 0 until two ticks after release.

Decomposition:
- Shared package:
  - field-code constants (FLD_X=0, FLD_Y=1, FLD_CTRL=2)
  - sprite-register struct {x, y, en, img}
  - SPR_W/SPR_H-derived log2 constants
- One natural sub-module, sprite_hit_unit, instantiated NUM_SPRITES times. It takes an active register set plus hcount/vcount and returns hit and the row/col offsets.

Test Plan:
- Reset, then sprite 0 at x=100, y=50, img=2, en via writes, then frame_start. Scan hcount=100, vcount=50 → two ticks later rom_addr=2<<10, pix_en=1, pixel=rom_data, hcount_o=100.
- Sprites 0 and 1 both cover (120,60) → rom_addr uses sprite 0's image and offsets; sprite 1 is not shown. Disable sprite 0 → sprite 1 wins.
- Write x=200 mid-frame → the old x=100 is still used until frame_start; the same-cycle write plus frame_start commits only next frame.
- Sprite at x=1000 → no hit at hcount 0..7; hits at 1000..1023.
- Sprite 0 and sprite 3 overlap at one pixel in frame N → collision=1 after frame_start of N+1. No overlap in N+1 → collision=0 after the next frame_start.
- bright=0 while a sprite covers the pixel → pix_en=0, pixel=0. Assert rst mid-scan → all outputs 0 immediately.
